// File: rtl/noc_axi_mem_slave.sv
// AXI4 burst responder backed by a flat single-port RAM; serves one INCR burst at a time.
// Stands in for the DDR/NoC path of the matrix-multiply engine during block-level work.
module noc_axi_mem_slave #(
   parameter int unsigned                AXI_ADDR_WIDTH = 64,
   parameter int unsigned                AXI_DATA_WIDTH = 128,
   parameter int unsigned                AXI_ID_WIDTH   = 16,
   parameter int unsigned                MEM_DEPTH      = 4096,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                    s_axi_awlen,
   input  logic [2:0]                    s_axi_awsize,
   input  logic [1:0]                    s_axi_awburst,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                          s_axi_wlast,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                    s_axi_arlen,
   input  logic [2:0]                    s_axi_arsize,
   input  logic [1:0]                    s_axi_arburst,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
   output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rlast,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready
);

   localparam int unsigned STRB_W    = AXI_DATA_WIDTH / 8;
   localparam int unsigned SIZE_LOG2 = $clog2(STRB_W);
   localparam int unsigned WORD_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A  = AXI_ADDR_WIDTH'(MEM_DEPTH);
   localparam logic [AXI_ADDR_WIDTH-1:0] WORD_INC = AXI_ADDR_WIDTH'(1);
   localparam logic [2:0]                BEAT_SIZE  = 3'(SIZE_LOG2);
   localparam logic [1:0]                BURST_INCR = 2'b01;
   localparam logic [1:0]                RESP_OKAY   = 2'b00;
   localparam logic [1:0]                RESP_SLVERR = 2'b10;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WR_DATA = 2'd1;
   localparam logic [1:0] WR_RESP = 2'd2;
   localparam logic [1:0] RD_DATA = 2'd3;

   logic [1:0]                state;
   logic                      last_rd;
   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [AXI_ADDR_WIDTH-1:0] wr_word;
   logic                      wr_below, wr_bad, wr_err;
   logic [7:0]                wr_len, wr_cnt;

   logic [AXI_ADDR_WIDTH-1:0] rd_word;
   logic                      rd_below, rd_bad;
   logic [7:0]                rd_len, rd_beat;
   logic [8:0]                rd_left;

   logic                      s1_valid, s1_err, s1_last;
   logic [AXI_DATA_WIDTH-1:0] s1_data;

   logic                      idle, aw_hs, ar_hs, w_hs;
   logic [AXI_ADDR_WIDTH:0]   aw_off, ar_off;
   logic                      wr_in_range, wr_last_exp, wr_beat_err, wr_store;
   logic                      rd_in_range, rd_issue, r_adv, rd_fetch;
   logic [WORD_W-1:0]         wr_idx, rd_idx;

   always_comb begin
      idle          = rstn && (state == IDLE);
      // Ready depends on the competing valid so only the round-robin winner sees a handshake.
      s_axi_awready = idle && (!s_axi_arvalid || last_rd);
      s_axi_arready = idle && (!s_axi_awvalid || !last_rd);
      s_axi_wready  = rstn && (state == WR_DATA);
      aw_hs         = s_axi_awvalid && s_axi_awready;
      ar_hs         = s_axi_arvalid && s_axi_arready;
      w_hs          = s_axi_wvalid && s_axi_wready;

      // Extra MSB catches addresses below BASE_ADDR as a borrow.
      aw_off        = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
      ar_off        = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};

      wr_in_range   = !wr_below && (wr_word < DEPTH_A);
      wr_last_exp   = (wr_cnt == wr_len);
      wr_beat_err   = !wr_in_range || wr_bad || (s_axi_wlast != wr_last_exp);
      wr_store      = w_hs && wr_in_range && !wr_bad;
      wr_idx        = wr_word[WORD_W-1:0];

      rd_in_range   = !rd_below && (rd_word < DEPTH_A);
      rd_issue      = (state == RD_DATA) && (rd_left != 9'd0);
      r_adv         = !s_axi_rvalid || s_axi_rready;
      rd_fetch      = rd_issue && r_adv;
      rd_idx        = rd_word[WORD_W-1:0];
   end

   // RAM array: never reset; illegal size/burst writes are dropped like out-of-range beats.
   always_ff @(posedge clk) begin
      if (rstn && wr_store) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
      if (rstn && rd_fetch) s1_data <= mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         last_rd      <= 1'b1;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_bid    <= '0;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= RESP_OKAY;
         s_axi_rid    <= '0;
         s_axi_rlast  <= 1'b0;
         s_axi_rdata  <= '0;
         s1_valid     <= 1'b0;
         s1_err       <= 1'b0;
         s1_last      <= 1'b0;
         wr_word      <= '0;
         wr_below     <= 1'b0;
         wr_bad       <= 1'b0;
         wr_err       <= 1'b0;
         wr_len       <= '0;
         wr_cnt       <= '0;
         rd_word      <= '0;
         rd_below     <= 1'b0;
         rd_bad       <= 1'b0;
         rd_len       <= '0;
         rd_beat      <= '0;
         rd_left      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  wr_word   <= aw_off[AXI_ADDR_WIDTH-1:0] >> SIZE_LOG2;
                  wr_below  <= aw_off[AXI_ADDR_WIDTH];
                  wr_bad    <= (s_axi_awsize != BEAT_SIZE) || (s_axi_awburst != BURST_INCR);
                  wr_err    <= 1'b0;
                  wr_len    <= s_axi_awlen;
                  wr_cnt    <= '0;
                  s_axi_bid <= s_axi_awid;
                  last_rd   <= 1'b0;
                  state     <= WR_DATA;
               end else if (ar_hs) begin
                  rd_word   <= ar_off[AXI_ADDR_WIDTH-1:0] >> SIZE_LOG2;
                  rd_below  <= ar_off[AXI_ADDR_WIDTH];
                  rd_bad    <= (s_axi_arsize != BEAT_SIZE) || (s_axi_arburst != BURST_INCR);
                  rd_len    <= s_axi_arlen;
                  rd_beat   <= '0;
                  rd_left   <= {1'b0, s_axi_arlen} + 9'd1;
                  s_axi_rid <= s_axi_arid;
                  last_rd   <= 1'b1;
                  state     <= RD_DATA;
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  wr_word <= wr_word + WORD_INC;
                  wr_cnt  <= wr_cnt + 8'd1;
                  wr_err  <= wr_err || wr_beat_err;
                  if (wr_last_exp) begin
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     state        <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  state        <= IDLE;
               end
            end
            RD_DATA: begin
               // Two-stage pipe (RAM read, output register) stalls as a unit on back-pressure.
               if (r_adv) begin
                  s_axi_rvalid <= s1_valid;
                  s_axi_rdata  <= s1_err ? '0 : s1_data;
                  s_axi_rresp  <= s1_err ? RESP_SLVERR : RESP_OKAY;
                  s_axi_rlast  <= s1_valid && s1_last;
                  s1_valid     <= rd_issue;
                  if (rd_issue) begin
                     s1_err  <= !rd_in_range || rd_bad;
                     s1_last <= (rd_beat == rd_len);
                     rd_left <= rd_left - 9'd1;
                     rd_word <= rd_word + WORD_INC;
                     rd_beat <= rd_beat + 8'd1;
                  end
               end
               if (s_axi_rvalid && s_axi_rready && s_axi_rlast) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_axi_mem_slave.sv
// Directed bench for noc_axi_mem_slave: bursts, strobes, arbitration, stalls, range and reset.
module tb_noc_axi_mem_slave;

   logic          clk = 1'b0;
   logic          rstn;
   logic [15:0]   awid, arid, bid, rid;
   logic [63:0]   awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [127:0]  wdata, rdata;
   logic [15:0]   wstrb;

   int            nvec = 0;
   int            nerr = 0;

   logic [127:0]  wbuf [16];
   logic [127:0]  rbuf [16];
   logic [1:0]    rrbuf [16];
   logic          rlbuf [16];
   int            nbeats, lat;
   logic [15:0]   got_rid;

   noc_axi_mem_slave #(
      .AXI_ADDR_WIDTH (64),
      .AXI_DATA_WIDTH (128),
      .AXI_ID_WIDTH   (16),
      .MEM_DEPTH      (4096),
      .BASE_ADDR      (64'h0)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axi_awid    (awid),
      .s_axi_awaddr  (awaddr),
      .s_axi_awlen   (awlen),
      .s_axi_awsize  (awsize),
      .s_axi_awburst (awburst),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wlast   (wlast),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bid     (bid),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_arid    (arid),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_arsize  (arsize),
      .s_axi_arburst (arburst),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rid     (rid),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rlast   (rlast),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] pat_word(input int k);
      return {8{16'h7100 + 16'(k)}};
   endfunction

   task automatic send_aw(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      logic ok = 1'b0;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         #1;
         ok = awready;
         tick();
      end
      awvalid = 1'b0;
      chk("aw_accept", 128'(ok), 128'd1);
   endtask

   task automatic send_ar(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      logic ok = 1'b0;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         #1;
         ok = arready;
         tick();
      end
      arvalid = 1'b0;
      chk("ar_accept", 128'(ok), 128'd1);
   endtask

   task automatic send_w(input logic [7:0] len, input logic [15:0] strb, input logic bad_last);
      logic all_ok = 1'b1;
      logic ok;
      for (int b = 0; b <= int'(len) && all_ok; b++) begin
         wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
         wlast  = (b == int'(len)) ^ bad_last;
         ok = 1'b0;
         for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = wready;
            tick();
         end
         all_ok = ok;
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("w_accept", 128'(all_ok), 128'd1);
   endtask

   task automatic get_b(output logic [1:0] resp, output logic [15:0] id);
      logic ok = 1'b0;
      resp = 2'bxx; id = 'x;
      bready = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (bvalid) begin
            ok = 1'b1; resp = bresp; id = bid;
         end
         tick();
      end
      bready = 1'b0;
      chk("b_valid", 128'(ok), 128'd1);
   endtask

   task automatic do_write(input string tag, input logic [15:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [15:0] strb, input logic [2:0] size,
                           input logic [1:0] burst, input logic bad_last, input logic [1:0] exp_resp);
      logic [1:0]  resp;
      logic [15:0] id_o;
      send_aw(id, addr, len, size, burst);
      send_w(len, strb, bad_last);
      get_b(resp, id_o);
      chk({tag, "_bresp"}, 128'(resp), 128'(exp_resp));
      chk({tag, "_bid"}, 128'(id_o), 128'(id));
   endtask

   // Collects beats right after an AR handshake; rready follows pat[cycle % 4].
   task automatic get_r(input logic [3:0] pat);
      logic         done = 1'b0;
      logic         stall = 1'b0;
      logic [127:0] h_data;
      logic [1:0]   h_resp;
      logic         h_last;
      nbeats = 0; lat = -1;
      for (int c = 0; c < 300 && !done; c++) begin
         rready = pat[c % 4];
         #1;
         if (stall) begin
            chk("r_hold_valid", 128'(rvalid), 128'd1);
            chk("r_hold_data", rdata, h_data);
            chk("r_hold_meta", 128'({rresp, rlast}), 128'({h_resp, h_last}));
         end
         if (rvalid && lat < 0) lat = c;
         if (rvalid && rready && nbeats < 16) begin
            rbuf[nbeats] = rdata; rrbuf[nbeats] = rresp; rlbuf[nbeats] = rlast;
            got_rid = rid;
            nbeats++;
            if (rlast) done = 1'b1;
         end
         stall = rvalid && !rready;
         h_data = rdata; h_resp = rresp; h_last = rlast;
         tick();
      end
      rready = 1'b0;
      chk("r_done", 128'(done), 128'd1);
   endtask

   task automatic check_meta(input string tag, input logic [15:0] id, input int beats);
      chk({tag, "_rid"}, 128'(got_rid), 128'(id));
      chk({tag, "_beats"}, 128'(nbeats), 128'(beats));
      chk({tag, "_latency"}, 128'(lat), 128'd2);
   endtask

   task automatic do_read(input string tag, input logic [15:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [3:0] pat);
      send_ar(id, addr, len, size, 2'b01);
      get_r(pat);
      check_meta(tag, id, int'(len) + 1);
   endtask

   initial begin
      logic        quiet;
      int          cnt;
      rstn = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

      tick(); tick();
      chk("rst_ready", 128'({awready, arready, wready}), 128'd0);
      chk("rst_valid", 128'({bvalid, rvalid, rlast}), 128'd0);
      chk("rst_resp", 128'({bresp, rresp}), 128'd0);
      chk("rst_ids", 128'({bid, rid}), 128'd0);
      rstn = 1'b1;
      tick();

      // Simultaneous AW/AR out of reset: write wins.
      wbuf[0] = 128'hC0DE_0000_1111_2222_3333_4444_5555_0001;
      wbuf[1] = 128'hC0DE_0000_1111_2222_3333_4444_5555_0002;
      wbuf[2] = 128'hC0DE_0000_1111_2222_3333_4444_5555_0003;
      wbuf[3] = 128'hC0DE_0000_1111_2222_3333_4444_5555_0004;
      awid = 16'h0A01; awaddr = 64'h40; awlen = 8'd3; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
      arid = 16'h0B02; araddr = 64'h40; arlen = 8'd3; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
      #1;
      chk("arb1_ready", 128'({awready, arready}), 128'b10);
      tick();
      // Read withdrawn so the next pair shows the alternation directly.
      awvalid = 1'b0; arvalid = 1'b0;
      begin
         logic [1:0]  r;
         logic [15:0] i;
         send_w(8'd3, 16'hFFFF, 1'b0);
         get_b(r, i);
         chk("wr4_bresp", 128'(r), 128'd0);
         chk("wr4_bid", 128'(i), 128'h0A01);
      end

      // Second simultaneous pair: read wins; the write stays pending behind it.
      awid = 16'h0A02; awaddr = 64'h140; awlen = 8'd0; awvalid = 1'b1;
      arid = 16'h0B02; araddr = 64'h40;  arlen = 8'd3; arvalid = 1'b1;
      #1;
      chk("arb2_ready", 128'({awready, arready}), 128'b01);
      tick();
      arvalid = 1'b0;
      get_r(4'b1111);
      check_meta("rd4", 16'h0B02, 4);
      chk("rd4_d0", rbuf[0], 128'hC0DE_0000_1111_2222_3333_4444_5555_0001);
      chk("rd4_d1", rbuf[1], 128'hC0DE_0000_1111_2222_3333_4444_5555_0002);
      chk("rd4_d2", rbuf[2], 128'hC0DE_0000_1111_2222_3333_4444_5555_0003);
      chk("rd4_d3", rbuf[3], 128'hC0DE_0000_1111_2222_3333_4444_5555_0004);
      chk("rd4_resp", 128'({rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3]}), 128'd0);
      chk("rd4_last", 128'({rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]}), 128'b0001);

      wbuf[0] = '1;
      do_write("wr_ones", 16'h0A02, 64'h140, 8'd0, 16'hFFFF, 3'd4, 2'b01, 1'b0, 2'b00);
      wbuf[0] = '0;
      do_write("wr_strb", 16'h0A03, 64'h140, 8'd0, 16'h0001, 3'd4, 2'b01, 1'b0, 2'b00);
      do_read("rd_strb", 16'h0B03, 64'h140, 8'd0, 3'd4, 4'b1111);
      chk("rd_strb_data", rbuf[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00);
      chk("rd_strb_last", 128'({rrbuf[0], rlbuf[0]}), 128'b001);

      // rready 1,0,0,1 over an 8-beat read.
      for (int k = 0; k < 8; k++) wbuf[k] = pat_word(k);
      do_write("wr8", 16'h0A04, 64'h200, 8'd7, 16'hFFFF, 3'd4, 2'b01, 1'b0, 2'b00);
      do_read("rd8", 16'h0B04, 64'h200, 8'd7, 3'd4, 4'b1001);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rd8_d%0d", k), rbuf[k], pat_word(k));
         chk($sformatf("rd8_m%0d", k), 128'({rrbuf[k], rlbuf[k]}), 128'({2'b00, k == 7}));
      end

      // Burst starting on the last word: second beat falls off the end.
      wbuf[0] = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      wbuf[1] = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111;
      do_write("wr_edge", 16'h0A05, 64'hFFF0, 8'd1, 16'hFFFF, 3'd4, 2'b01, 1'b0, 2'b10);
      do_read("rd_edge", 16'h0B05, 64'hFFF0, 8'd1, 3'd4, 4'b1111);
      chk("rd_edge_d0", rbuf[0], 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
      chk("rd_edge_m0", 128'({rrbuf[0], rlbuf[0]}), 128'b000);
      chk("rd_edge_d1", rbuf[1], 128'd0);
      chk("rd_edge_m1", 128'({rrbuf[1], rlbuf[1]}), 128'b101);

      // Protocol errors: FIXED burst, narrow size, early wlast.
      wbuf[0] = 128'h5;
      wbuf[1] = 128'h6;
      do_write("wr_fixed", 16'h0A06, 64'h300, 8'd0, 16'hFFFF, 3'd4, 2'b00, 1'b0, 2'b10);
      do_write("wr_narrow", 16'h0A07, 64'h300, 8'd0, 16'hFFFF, 3'd2, 2'b01, 1'b0, 2'b10);
      do_write("wr_wlast", 16'h0A08, 64'h300, 8'd1, 16'hFFFF, 3'd4, 2'b01, 1'b1, 2'b10);
      do_read("rd_narrow", 16'h0B06, 64'h40, 8'd0, 3'd2, 4'b1111);
      chk("rd_narrow_data", rbuf[0], 128'd0);
      chk("rd_narrow_resp", 128'(rrbuf[0]), 128'b10);

      // Reset while beat 2 of an 8-beat read is on the bus.
      send_ar(16'h0B07, 64'h200, 8'd7, 3'd4, 2'b01);
      rready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 40 && cnt < 2; c++) begin
         #1;
         if (rvalid && rready) cnt++;
         tick();
      end
      chk("rst_pre_beats", 128'(cnt), 128'd2);
      chk("rst_beat2", rdata, pat_word(2));
      rstn = 1'b0;
      tick();
      chk("rst_rvalid", 128'(rvalid), 128'd0);
      rstn = 1'b1;
      quiet = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (rvalid) quiet = 1'b0;
      end
      rready = 1'b0;
      chk("rst_quiet", 128'(quiet), 128'd1);
      do_read("rd_after", 16'h0B08, 64'h250, 8'd0, 3'd4, 4'b1111);
      chk("rd_after_data", rbuf[0], pat_word(5));
      chk("rd_after_m", 128'({rrbuf[0], rlbuf[0]}), 128'b001);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
